// File: rtl/mathbox_useq.sv
// Loadable microcode store and sequencer for the math-box datapath.
// Walks microwords from a start address, handling jump/branch/stop and a step watchdog.
module mathbox_useq #(
  parameter int unsigned UWIDTH    = 24,
  parameter int unsigned AWIDTH    = 8,
  parameter int unsigned TGT_LSB   = 16,
  parameter int unsigned SEQ_LSB   = 14,
  parameter int unsigned MAX_STEPS = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_we,
  input  logic [AWIDTH-1:0] load_addr,
  input  logic [UWIDTH-1:0] load_data,
  input  logic              start,
  input  logic [AWIDTH-1:0] start_addr,
  input  logic              cond_in,
  input  logic              hold,
  output logic [UWIDTH-1:0] uword,
  output logic              uword_valid,
  output logic [AWIDTH-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              abort
);

  localparam int unsigned DEPTH  = 2 ** AWIDTH;
  localparam int unsigned SWIDTH = $clog2(MAX_STEPS + 1);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  state_t            state_q, state_d;
  logic [UWIDTH-1:0] mem [DEPTH];
  logic [SWIDTH-1:0] steps_q, steps_d, steps_inc;
  logic [AWIDTH-1:0] pc_d;
  logic              done_d, abort_d;
  logic [1:0]        op;
  logic [AWIDTH-1:0] tgt;

  assign op        = uword[SEQ_LSB +: 2];
  assign tgt       = uword[TGT_LSB +: AWIDTH];
  assign steps_inc = steps_q + SWIDTH'(1);

  // Microcode write port; only honoured while the sequencer is idle
  always_ff @(posedge clk) begin
    if (load_we && state_q == IDLE) mem[load_addr] <= load_data;
  end

  // Next-state, program counter and completion decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    steps_d = steps_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = start_addr;
          steps_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        if (!hold) begin
          steps_d = steps_inc;
          if (op == 2'b11) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            if (op == 2'b01 || (op == 2'b10 && cond_in)) pc_d = tgt;
            else                                          pc_d = pc + AWIDTH'(1);
            if (steps_inc == SWIDTH'(MAX_STEPS)) begin
              abort_d = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = FETCH;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; uword doubles as the synchronous RAM read register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc          <= '0;
      steps_q     <= '0;
      done        <= 1'b0;
      abort       <= 1'b0;
      busy        <= 1'b0;
      uword_valid <= 1'b0;
      uword       <= '0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      steps_q     <= steps_d;
      done        <= done_d;
      abort       <= abort_d;
      busy        <= (state_d != IDLE);
      uword_valid <= (state_d == EXEC);
      if (state_q == FETCH) uword <= mem[pc];
    end
  end

endmodule

// File: tb/tb_mathbox_useq.sv
// Randomised self-checking bench for mathbox_useq against a microword-level program model.
module tb_mathbox_useq;

  localparam int unsigned UW  = 24;
  localparam int unsigned AW  = 8;
  localparam int unsigned MAX = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [UW-1:0] load_data;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          cond_in;
  logic          hold;
  logic [UW-1:0] uword;
  logic          uword_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          abort;

  logic [UW-1:0] mem_m [256];
  int n_vec = 0;
  int n_err = 0;

  mathbox_useq #(.UWIDTH(UW), .AWIDTH(AW), .TGT_LSB(16), .SEQ_LSB(14), .MAX_STEPS(MAX)) dut (
    .clk(clk), .reset_n(reset_n), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .start(start), .start_addr(start_addr), .cond_in(cond_in),
    .hold(hold), .uword(uword), .uword_valid(uword_valid), .pc(pc), .busy(busy),
    .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [UW-1:0] mk(input logic [1:0] op, input logic [7:0] tgt);
    logic [13:0] low;
    low = 14'($urandom);
    return {tgt, op, low};
  endfunction

  // Write one word while idle; the model tracks it
  task automatic load(input logic [7:0] a, input logic [UW-1:0] d);
    load_we = 1'b1; load_addr = a; load_data = d; mem_m[a] = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // One program run; entered and left at a negedge with the sequencer idle
  task automatic run(input logic [7:0] sa, input int hold_pct, input int cond_mode,
                     input int hold_addr, input bit load_at_start, input int poke_addr,
                     input bit noise);
    logic [7:0]    p;
    logic [UW-1:0] w;
    logic [1:0]    op;
    logic          c;
    int            steps, hcnt;
    bit            fin, is_stop, first;
    p = sa; steps = 0; fin = 0; is_stop = 0; first = 1; c = 1'b0;
    start = 1'b1; start_addr = sa;
    if (load_at_start) begin
      w = mk(2'b11, 8'h00);
      load_we = 1'b1; load_addr = sa; load_data = w; mem_m[sa] = w;
    end
    while (!fin) begin
      @(negedge clk);
      start = 1'b0; load_we = 1'b0; hold = 1'b0;
      check("fetch_busy", 32'(busy), 32'd1);
      check("fetch_valid", 32'(uword_valid), 32'd0);
      check("fetch_pc", 32'(pc), 32'(p));
      check("fetch_done_abort", 32'({done, abort}), 32'd0);
      if (first && poke_addr >= 0) begin
        load_we = 1'b1; load_addr = 8'(poke_addr); load_data = 24'($urandom);
      end
      first = 0;
      if (noise) begin
        start = 1'($urandom); start_addr = 8'($urandom);
        load_we = 1'($urandom); load_addr = 8'($urandom); load_data = 24'($urandom);
      end
      w = mem_m[p];
      hcnt = (int'(p) == hold_addr) ? 5 : 0;
      do begin
        @(negedge clk);
        start = 1'b0; load_we = 1'b0;
        check("exec_valid", 32'(uword_valid), 32'd1);
        check("exec_uword", 32'(uword), 32'(w));
        check("exec_pc", 32'(pc), 32'(p));
        check("exec_busy_done_abort", 32'({busy, done, abort}), 32'b100);
        if (noise) begin
          start = 1'($urandom); start_addr = 8'($urandom);
          load_we = 1'($urandom); load_addr = 8'($urandom); load_data = 24'($urandom);
        end
        if (hcnt > 0) begin
          hold = 1'b1; hcnt--;
        end else begin
          hold = ($urandom_range(99) < hold_pct);
        end
        c = (cond_mode == 2) ? 1'($urandom) : 1'(cond_mode);
        cond_in = c;
      end while (hold);
      steps++;
      op = w[15:14];
      if (op == 2'b11) begin
        fin = 1; is_stop = 1;
      end else begin
        p = (op == 2'b01 || (op == 2'b10 && c)) ? w[23:16] : p + 8'd1;
        if (steps == int'(MAX)) fin = 1;
      end
    end
    @(negedge clk);
    start = 1'b0; load_we = 1'b0; hold = 1'b0;
    check("end_busy_valid", 32'({busy, uword_valid}), 32'd0);
    check("end_done", 32'(done), 32'(is_stop));
    check("end_abort", 32'(abort), 32'(!is_stop));
    check("end_pc", 32'(pc), 32'(p));
    check("end_uword", 32'(uword), 32'(w));
  endtask

  initial begin
    logic [UW-1:0] w30;
    reset_n = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; start_addr = '0; cond_in = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", 32'({uword_valid, busy, done, abort}), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_uword", 32'(uword), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Straight-line program ending in stop
    load(8'h00, mk(2'b00, 8'h77)); load(8'h01, mk(2'b00, 8'h55));
    load(8'h02, mk(2'b00, 8'h00)); load(8'h03, mk(2'b11, 8'h12));
    run(8'h00, 0, 0, -1, 0, -1, 0);

    // Conditional branch taken and not taken
    load(8'h10, mk(2'b10, 8'h40)); load(8'h40, mk(2'b11, 8'h00)); load(8'h11, mk(2'b11, 8'h00));
    run(8'h10, 0, 1, -1, 0, -1, 0);
    run(8'h10, 0, 0, -1, 0, -1, 0);

    // Address wrap from top of store
    load(8'hFF, mk(2'b00, 8'h33)); load(8'h00, mk(2'b11, 8'h00));
    run(8'hFF, 0, 2, -1, 0, -1, 0);

    // Self-loop hits the watchdog, restart accepted immediately after
    load(8'h20, mk(2'b01, 8'h20)); load(8'h21, mk(2'b11, 8'h00));
    run(8'h20, 0, 2, -1, 0, -1, 0);
    run(8'h21, 0, 2, -1, 0, -1, 0);

    // Five-cycle stall on 0x01
    load(8'h00, mk(2'b00, 8'h00));
    run(8'h00, 0, 2, 1, 0, -1, 0);

    // Write to 0x30 mid-run is dropped; start with same-cycle load uses new data
    w30 = mk(2'b11, 8'h00);
    load(8'h30, w30);
    run(8'h21, 0, 2, -1, 0, 8'h30, 0);
    run(8'h30, 0, 2, -1, 0, -1, 0);
    run(8'h50, 0, 2, -1, 1, -1, 0);

    // Reset mid-run clears outputs without waiting for a clock
    start = 1'b1; start_addr = 8'h00;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_flags", 32'({uword_valid, busy, done, abort}), 32'd0);
    check("async_rst_pc_uword", 32'({pc, uword}), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'({uword_valid, busy, done, abort}), 32'd0);

    // Random programs with stalls, branch conditions and ignored traffic
    for (int i = 0; i < 256; i++) begin
      logic [1:0] op;
      op = 2'($urandom);
      load(8'(i), mk(op, 8'($urandom)));
    end
    for (int r = 0; r < 60; r++) begin
      run(8'($urandom), 30, 2, -1, 1'($urandom_range(9) == 0), -1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mathbox_useq.md
Name: mathbox_useq

Overview:
- Parametrised microcode store plus sequencer for the math-box datapath; the next generation of the fixed 256x24 microcode ROM.
- Microcode is held in a loadable synchronous RAM and written through a load port while the sequencer is idle.
- The sequencer walks microwords from a given start address, executing jump, conditional-jump and stop operations encoded in each word.
- Each fetched microword is presented to the datapath with a valid strobe and a hold (stall) input; a step watchdog aborts runaway programs.

Parameters:
UWIDTH, 24, microword width in bits.
AWIDTH, 8, microcode address width; depth = 2**AWIDTH.
TGT_LSB, 16, LSB of the AWIDTH-bit branch-target field within the microword.
SEQ_LSB, 14, LSB of the 2-bit sequence-op field within the microword.
MAX_STEPS, 1024, maximum microwords executed per run before abort; must be >= 1.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
load_we  in  1  microcode write strobe; honoured only in IDLE.
load_addr  in  AWIDTH  microcode write address.
load_data  in  UWIDTH  microcode write data.
start  in  1  run request; accepted only in IDLE.
start_addr  in  AWIDTH  first microword address, sampled with start.
cond_in  in  1  branch condition from the datapath, sampled in EXEC.
hold  in  1  datapath stall; freezes the sequencer in EXEC.
uword  out  UWIDTH  current microword.
uword_valid  out  1  uword is valid for the datapath this cycle.
pc  out  AWIDTH  address of the current or next fetched microword.
busy  out  1  high in FETCH and EXEC.
done  out  1  one-cycle pulse on normal stop.
abort  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async assert, sync release): state IDLE; uword=0, uword_valid=0, pc=0, busy=0, done=0, abort=0, step count=0. RAM contents are not reset.
- Reset mid-run aborts immediately, with no done or abort pulse.
- RAM: one write port and one read port, both synchronous. In IDLE, load_we writes load_data to load_addr on the clock edge. load_we outside IDLE is ignored.
- States: IDLE, FETCH, EXEC.
- IDLE: if start, set pc<=start_addr, steps<=0, go to FETCH. Otherwise stay.
  - A load_we in the same cycle as start is still performed.
  - FETCH reads the RAM on the following edge, so it sees the newly written data.
- FETCH (1 cycle): RAM read of pc; go to EXEC.
- EXEC:
  - Entry: uword<=RAM data; uword_valid=1 for the whole EXEC stay.
  - While hold=1: remain in EXEC; uword, pc and steps are frozen.
  - When hold=0: steps<=steps+1, then decode op = uword[SEQ_LSB+1:SEQ_LSB] and tgt = uword[TGT_LSB+AWIDTH-1:TGT_LSB]:
    - 00 continue: pc<=pc+1, wrapping modulo 2**AWIDTH.
    - 01 jump: pc<=tgt.
    - 10 conditional: pc<=tgt if cond_in=1, else pc+1.
    - 11 stop: done=1 for one cycle, go to IDLE. pc keeps the stop-word address.
  - For ops 00/01/10: if the incremented steps == MAX_STEPS, pulse abort for one cycle and go to IDLE. Otherwise go to FETCH.
  - Stop takes priority over abort when both would occur on the same word.
- Cadence: 2 cycles per microword without hold.
  - Latency from the start edge to the first uword_valid=1 is 2 cycles.
  - uword_valid=0 in FETCH and IDLE.
  - uword retains its last value after the run ends.
- busy=1 exactly in FETCH and EXEC.
- start while busy is ignored.
- done and abort are never high together.

Test Plan:
- Load addresses 0x00-0x03 with op=00 at 0x00-0x02 and op=11 at 0x03; start at 0x00 -> uword_valid pulses on cycles 2, 4, 6, 8; pc sequence 00,01,02,03; done pulses the cycle after the 0x03 EXEC; busy drops with it.
- Word at 0x10 op=10 tgt=0x40; run once with cond_in=1 -> next pc=0x40; run again with cond_in=0 -> next pc=0x11.
- Word at 0xFF op=00, word at 0x00 op=11; start at 0xFF -> pc wraps to 0x00, then done.
- MAX_STEPS=4 with word 0x20 op=01 tgt=0x20 -> abort pulses after the 4th EXEC; no done; state returns to IDLE; start_addr 0x21 can be accepted the next cycle.
- hold=1 for 5 cycles during EXEC of 0x01 -> uword and pc stable, uword_valid held high, step count unchanged; resumes on hold=0.
- load_we to 0x30 during a run is ignored (a later readback run shows the old word). Simultaneous start+load_we to start_addr in IDLE -> first uword equals the new data. Reset_n pulsed low mid-run -> all outputs 0 asynchronously.
